ts_ordered_set_filter: RTL and testbench
========================================

Name: ts_ordered_set_filter

Overview:
- Sits directly downstream of the ordered-set decoder in the PCIe RX LTSSM path.
- Consumes one aligned 16-symbol (128-bit) 8b/10b ordered set per valid cycle.
- Classifies each set as TS1, TS2, SKP or other, and latches the TS fields.
- Counts consecutive identical TS1/TS2 sets and flags to the LTSSM when the required run length is reached (e.g. 8 consecutive TS1 in Polling.Active).

Parameters:
- THRESHOLD, 8, consecutive-identical-TS count at which the ts*_seen flags assert.
- COUNT_W, 5, width of the run counters; counters saturate at 2^COUNT_W-1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- os_valid  input  1  os_data holds a complete ordered set this cycle
- os_data  input  128  symbol 0 (COM) in [127:120], symbol 15 in [7:0]
- clear  input  1  synchronous run restart, pulsed by LTSSM on state change
- ts_valid  output  1  one-cycle pulse: a TS1/TS2 was accepted last cycle
- ts_type  output  1  0=TS1, 1=TS2 for the last accepted TS
- link_num  output  8  symbol 1 of the last accepted TS
- lane_num  output  8  symbol 2 of the last accepted TS
- n_fts  output  8  symbol 3 of the last accepted TS
- rate_id  output  8  symbol 4 of the last accepted TS
- train_ctrl  output  8  symbol 5 of the last accepted TS
- run_count  output  COUNT_W  current consecutive-identical count
- ts1_seen  output  1  run_count>=THRESHOLD and run is TS1
- ts2_seen  output  1  run_count>=THRESHOLD and run is TS2
- err_count  output  8  malformed-set counter (see Optional Feature)

Behaviour:
- Reset (reset low, async): all outputs 0, state IDLE, stored previous-TS register 0.
- Classification, combinational on os_data when os_valid=1:
  - TS1: sym0=BC, sym6..15 all 4A.
  - TS2: sym0=BC, sym6..15 all 45.
  - SKP: sym0=BC, sym1..3 all 1C.
  - Other: anything else.
- Identical: sym1..15 equal to the stored previous TS.
- States: IDLE, TS1_RUN, TS2_RUN.
  - IDLE + TS1 -> TS1_RUN, run_count=1. IDLE + TS2 -> TS2_RUN, run_count=1.
  - TSx_RUN + identical TSx -> stay, run_count+1, saturating at 2^COUNT_W-1.
  - TSx_RUN + TS not identical (different type or any field differs) -> new run of the received type, run_count=1.
  - Any state + SKP -> no change. SKP never breaks a run and never updates fields.
  - Any state + Other -> IDLE, run_count=0, fields hold their last values.
- Every accepted TS1/TS2:
  - Stored as the new previous TS.
  - link_num..train_ctrl and ts_type updated.
  - ts_valid pulses for one cycle.
- Latency: all outputs registered, update on the clk edge following the os_valid cycle. ts1_seen/ts2_seen derive from the registered state and count, same cycle as run_count.
- os_valid=0: no state change, ts_valid=0.
- clear=1: state IDLE, run_count=0, ts*_seen=0 next cycle. clear wins over a simultaneous os_valid; that set is discarded. Fields hold. err_count is not cleared.
- Reset asserted mid-run: immediate return to reset values. First TS after release starts count at 1.
- THRESHOLD > 2^COUNT_W-1 is illegal; flags would never assert.

Optional Feature:
- Macro: TS_MALFORMED_ERR_CNT_EN.
- Defined:
  - err_count increments, saturating at FF, on each os_valid set with sym0=BC that is classified Other.
  - Such a set is still treated as Other (run broken).
  - Cleared only by reset.
- Undefined: err_count tied to 0; no counter logic synthesised.

Test Plan:
- Reset low then high; 8 identical TS1 (link F7, lane F7, n_fts 10, rate 02, ctrl 00) on consecutive cycles -> run_count 1..8; ts1_seen=1 in the cycle after the 8th; link_num=F7, n_fts=10.
- 5 identical TS1, a SKP (BC 1C 1C 1C), then 3 more identical TS1 -> run_count reaches 8, ts1_seen=1 (SKP does not break the run).
- 4 TS1 then 1 TS1 with lane_num 00 instead of F7 -> run_count=1, lane_num=00, ts1_seen=0. Then 8 TS2 -> ts2_seen=1, ts_type=1.
- Run of 6 TS1, then an all-zero set -> state IDLE, run_count=0. With macro defined, set BC followed by 4A x9 and 00 -> err_count=1 and run reset.
- clear=1 and os_valid=1 with a TS2 in the same cycle during a TS1 run of 8 -> run_count=0, ts1_seen=0, ts_valid=0, fields unchanged.
- 40 identical TS1 with COUNT_W=5 -> run_count saturates at 31, ts1_seen held at 1.

Source files
------------

// File: rtl/ts_ordered_set_filter.sv
// TS1/TS2/SKP ordered-set classifier and consecutive-identical run counter for the RX LTSSM.
// Define TS_MALFORMED_ERR_CNT_EN to enable the malformed-set (COM but unclassifiable) counter.
module ts_ordered_set_filter #(
  parameter int unsigned THRESHOLD = 8,
  parameter int unsigned COUNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               os_valid,
  input  logic [127:0]       os_data,
  input  logic               clear,
  output logic               ts_valid,
  output logic               ts_type,
  output logic [7:0]         link_num,
  output logic [7:0]         lane_num,
  output logic [7:0]         n_fts,
  output logic [7:0]         rate_id,
  output logic [7:0]         train_ctrl,
  output logic [COUNT_W-1:0] run_count,
  output logic               ts1_seen,
  output logic               ts2_seen,
  output logic [7:0]         err_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TS1_RUN = 2'd1;
  localparam logic [1:0] TS2_RUN = 2'd2;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [1:0]   state;
  logic [119:0] prev_ts;
  logic [7:0]   sym [16];
  logic         is_ts1, is_ts2, is_skp, is_ts, identical, same_run;

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      sym[i] = os_data[127 - 8*i -: 8];
    end
  end

  always_comb begin
    is_ts1 = (sym[0] == 8'hBC);
    is_ts2 = (sym[0] == 8'hBC);
    for (int unsigned i = 6; i < 16; i++) begin
      is_ts1 = is_ts1 && (sym[i] == 8'h4A);
      is_ts2 = is_ts2 && (sym[i] == 8'h45);
    end
    is_skp = (sym[0] == 8'hBC) && (sym[1] == 8'h1C) && (sym[2] == 8'h1C) && (sym[3] == 8'h1C);
    is_ts  = is_ts1 || is_ts2;
  end

  // A run continues only when the incoming set matches both the run type and every stored symbol.
  assign identical = (os_data[119:0] == prev_ts);
  assign same_run  = identical &&
                     (((state == TS1_RUN) && is_ts1) || ((state == TS2_RUN) && is_ts2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      run_count  <= '0;
      prev_ts    <= '0;
      ts_valid   <= 1'b0;
      ts_type    <= 1'b0;
      link_num   <= '0;
      lane_num   <= '0;
      n_fts      <= '0;
      rate_id    <= '0;
      train_ctrl <= '0;
    end else begin
      ts_valid <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        run_count <= '0;
      end else if (os_valid) begin
        if (is_ts) begin
          state      <= is_ts2 ? TS2_RUN : TS1_RUN;
          run_count  <= same_run ? ((run_count == CNT_MAX) ? run_count : run_count + 1'b1)
                                 : COUNT_W'(1);
          prev_ts    <= os_data[119:0];
          ts_type    <= is_ts2;
          link_num   <= sym[1];
          lane_num   <= sym[2];
          n_fts      <= sym[3];
          rate_id    <= sym[4];
          train_ctrl <= sym[5];
          ts_valid   <= 1'b1;
        end else if (!is_skp) begin
          state     <= IDLE;
          run_count <= '0;
        end
      end
    end
  end

  assign ts1_seen = (state == TS1_RUN) && (32'(run_count) >= THRESHOLD);
  assign ts2_seen = (state == TS2_RUN) && (32'(run_count) >= THRESHOLD);

`ifdef TS_MALFORMED_ERR_CNT_EN
  logic malformed;
  assign malformed = os_valid && !clear && (sym[0] == 8'hBC) && !is_ts && !is_skp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (malformed && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_ts_ordered_set_filter.sv
// Self-checking bench for ts_ordered_set_filter: directed scenarios plus randomized traffic
// compared against a symbol-level reference model.
module tb_ts_ordered_set_filter;

  localparam int THRESHOLD = 8;
  localparam int COUNT_W   = 5;
  localparam int CNT_MAX   = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               os_valid;
  logic [127:0]       os_data;
  logic               clear;
  logic               ts_valid, ts_type;
  logic [7:0]         link_num, lane_num, n_fts, rate_id, train_ctrl, err_count;
  logic [COUNT_W-1:0] run_count;
  logic               ts1_seen, ts2_seen;

  ts_ordered_set_filter #(.THRESHOLD(THRESHOLD), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset), .os_valid(os_valid), .os_data(os_data), .clear(clear),
    .ts_valid(ts_valid), .ts_type(ts_type), .link_num(link_num), .lane_num(lane_num),
    .n_fts(n_fts), .rate_id(rate_id), .train_ctrl(train_ctrl), .run_count(run_count),
    .ts1_seen(ts1_seen), .ts2_seen(ts2_seen), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode 0 = no run, 1 = TS1 run, 2 = TS2 run.
  int       m_mode, m_cnt, m_err;
  bit [7:0] m_prev [16];
  bit [7:0] m_fld [1:5];
  bit       m_type, m_tsv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] symbol(input logic [127:0] d, input int i);
    return 8'(d >> (8 * (15 - i)));
  endfunction

  function automatic logic [127:0] make_ts(input bit t2, input bit [7:0] lk, input bit [7:0] ln,
                                           input bit [7:0] nf, input bit [7:0] rt, input bit [7:0] tc);
    return {8'hBC, lk, ln, nf, rt, tc, {10{t2 ? 8'h45 : 8'h4A}}};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_err = 0; m_type = 0; m_tsv = 0;
    foreach (m_prev[i]) m_prev[i] = '0;
    foreach (m_fld[i]) m_fld[i] = '0;
  endtask

  task automatic model_step(input bit v, input logic [127:0] d, input bit c);
    int  kind;
    bit  all4a, all45, same;
    m_tsv = 0;
    if (c) begin
      m_mode = 0; m_cnt = 0;
    end else if (v) begin
      all4a = 1; all45 = 1;
      for (int i = 6; i < 16; i++) begin
        if (symbol(d, i) != 8'h4A) all4a = 0;
        if (symbol(d, i) != 8'h45) all45 = 0;
      end
      if (symbol(d, 0) != 8'hBC) kind = 0;
      else if (all4a) kind = 1;
      else if (all45) kind = 2;
      else if (symbol(d, 1) == 8'h1C && symbol(d, 2) == 8'h1C && symbol(d, 3) == 8'h1C) kind = 3;
      else kind = 0;
      if (kind == 1 || kind == 2) begin
        same = (m_mode == kind);
        for (int i = 1; i < 16; i++) if (symbol(d, i) != m_prev[i]) same = 0;
        m_cnt  = same ? ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX) : 1;
        m_mode = kind;
        for (int i = 1; i < 16; i++) m_prev[i] = symbol(d, i);
        for (int i = 1; i <= 5; i++) m_fld[i] = symbol(d, i);
        m_type = (kind == 2);
        m_tsv  = 1;
      end else if (kind == 0) begin
        m_mode = 0; m_cnt = 0;
`ifdef TS_MALFORMED_ERR_CNT_EN
        if (symbol(d, 0) == 8'hBC && m_err < 255) m_err++;
`endif
      end
    end
  endtask

  task automatic compare_all();
    check("ts_valid",   32'(ts_valid),   32'(m_tsv));
    check("ts_type",    32'(ts_type),    32'(m_type));
    check("link_num",   32'(link_num),   32'(m_fld[1]));
    check("lane_num",   32'(lane_num),   32'(m_fld[2]));
    check("n_fts",      32'(n_fts),      32'(m_fld[3]));
    check("rate_id",    32'(rate_id),    32'(m_fld[4]));
    check("train_ctrl", 32'(train_ctrl), 32'(m_fld[5]));
    check("run_count",  32'(run_count),  32'(m_cnt));
    check("ts1_seen",   32'(ts1_seen),   32'(m_mode == 1 && m_cnt >= THRESHOLD));
    check("ts2_seen",   32'(ts2_seen),   32'(m_mode == 2 && m_cnt >= THRESHOLD));
    check("err_count",  32'(err_count),  32'(m_err));
  endtask

  task automatic apply(input bit v, input logic [127:0] d, input bit c);
    @(negedge clk);
    os_valid = v; os_data = d; clear = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    compare_all();
  endtask

  logic [127:0] ta, ta_lane0, tb2, skp, zero_set, bad_set, rnd;
  bit [7:0]     r_lk, r_ln, r_nf, r_rt, r_tc;
  bit           r_t2;
  int           r;

  initial begin
    ta       = make_ts(1'b0, 8'hF7, 8'hF7, 8'h10, 8'h02, 8'h00);
    ta_lane0 = make_ts(1'b0, 8'hF7, 8'h00, 8'h10, 8'h02, 8'h00);
    tb2      = make_ts(1'b1, 8'hF7, 8'hF7, 8'h10, 8'h02, 8'h00);
    skp      = {8'hBC, {15{8'h1C}}};
    zero_set = '0;
    bad_set  = {8'hBC, {9{8'h4A}}, 8'h00, {5{8'h4A}}};

    reset = 1'b0; os_valid = 1'b0; os_data = '0; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    @(negedge clk) reset = 1'b1;

    // Eight identical TS1 reach the threshold.
    for (int i = 1; i <= 8; i++) begin
      apply(1, ta, 0);
      check("run_count_seq", 32'(run_count), 32'(i));
    end
    check("ts1_seen_at_8", 32'(ts1_seen), 32'd1);
    check("link_f7", 32'(link_num), 32'hF7);
    check("nfts_10", 32'(n_fts), 32'h10);

    // SKP inside a run does not break it.
    apply(1, zero_set, 0);
    repeat (5) apply(1, ta, 0);
    apply(1, skp, 0);
    check("skp_no_tsv", 32'(ts_valid), 32'd0);
    repeat (3) apply(1, ta, 0);
    check("skp_run_8", 32'(run_count), 32'd8);
    check("skp_seen", 32'(ts1_seen), 32'd1);

    // A changed field restarts the run; then a TS2 run.
    apply(1, zero_set, 0);
    repeat (4) apply(1, ta, 0);
    apply(1, ta_lane0, 0);
    check("lane_restart_cnt", 32'(run_count), 32'd1);
    check("lane_00", 32'(lane_num), 32'h00);
    check("lane_seen0", 32'(ts1_seen), 32'd0);
    repeat (8) apply(1, tb2, 0);
    check("ts2_seen", 32'(ts2_seen), 32'd1);
    check("ts2_type", 32'(ts_type), 32'd1);

    // Other set ends a run; malformed COM set.
    repeat (6) apply(1, ta, 0);
    apply(1, zero_set, 0);
    check("other_idle_cnt", 32'(run_count), 32'd0);
    repeat (2) apply(1, ta, 0);
    apply(1, bad_set, 0);
    check("bad_cnt0", 32'(run_count), 32'd0);
`ifdef TS_MALFORMED_ERR_CNT_EN
    check("err_one", 32'(err_count), 32'd1);
`else
    check("err_zero", 32'(err_count), 32'd0);
`endif

    // Clear wins over a simultaneous TS2.
    repeat (8) apply(1, ta, 0);
    apply(1, tb2, 1);
    check("clr_cnt", 32'(run_count), 32'd0);
    check("clr_seen", 32'(ts1_seen), 32'd0);
    check("clr_tsv", 32'(ts_valid), 32'd0);
    check("clr_type", 32'(ts_type), 32'd0);
    check("clr_link", 32'(link_num), 32'hF7);

    // Counter saturation.
    repeat (40) apply(1, ta, 0);
    check("sat_cnt", 32'(run_count), 32'(CNT_MAX));
    check("sat_seen", 32'(ts1_seen), 32'd1);

    // Asynchronous reset mid-run.
    repeat (3) apply(1, ta, 0);
    @(negedge clk);
    os_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk) reset = 1'b1;
    apply(1, ta, 0);
    check("post_reset_cnt", 32'(run_count), 32'd1);

    // Randomized traffic around a slowly changing TS template.
    r_t2 = 0; r_lk = 8'h01; r_ln = 8'h02; r_nf = 8'h20; r_rt = 8'h02; r_tc = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      if (r < 55) begin
        apply(1, make_ts(r_t2, r_lk, r_ln, r_nf, r_rt, r_tc), 0);
      end else if (r < 62) begin
        r_t2 = ~r_t2;
        apply(1, make_ts(r_t2, r_lk, r_ln, r_nf, r_rt, r_tc), 0);
      end else if (r < 68) begin
        case ($urandom_range(0, 4))
          0: r_lk = 8'($urandom);
          1: r_ln = 8'($urandom);
          2: r_nf = 8'($urandom);
          3: r_rt = 8'($urandom);
          default: r_tc = 8'($urandom);
        endcase
        apply(1, make_ts(r_t2, r_lk, r_ln, r_nf, r_rt, r_tc), 0);
      end else if (r < 75) begin
        apply(1, skp, 0);
      end else if (r < 79) begin
        if ($urandom_range(0, 1) == 1) rnd[127:120] = 8'hBC;
        apply(1, rnd, 0);
      end else if (r < 83) begin
        apply(1, bad_set, 0);
      end else if (r < 90) begin
        apply(0, make_ts(~r_t2, r_lk, r_ln, r_nf, r_rt, r_tc), 0);
      end else if (r < 93) begin
        apply(1'($urandom), make_ts(r_t2, r_lk, r_ln, r_nf, r_rt, r_tc), 1);
      end else begin
        apply(1, zero_set, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
